// File: rtl/coe_load_arbiter_pkg.sv
// Shared definitions for the COE loader / RAM write-port arbiter.
//   coe_state_t    : arbiter states (RUN, HDR, DATA, RELEASE, ERR)
//   HDR_BYTES      : bytes in the word-count header
//   BYTES_PER_WORD : bytes per RAM word
//   put_lane()     : little-endian byte-lane insert (lane 0 = bits [7:0])
package coe_load_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HDR,
        ST_DATA,
        ST_RELEASE,
        ST_ERR
    } coe_state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    // Little-endian convention: the k-th received byte of a word lands in lane k.
    function automatic logic [31:0] put_lane(input logic [31:0]       word,
                                             input logic [LANE_W-1:0] lane,
                                             input logic [7:0]        b);
        logic [31:0] r;
        r = word;
        r[8*lane +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/coe_load_arbiter_btn_edge_sync.sv
// btn_edge_sync: 2-flop synchroniser for an asynchronous button followed by a
// registered rising-edge detector.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   btn_i   : raw, asynchronous button level
//   pulse_o : one-cycle pulse, asserted on the third clock edge after the rise
module btn_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic meta_q, sync_q, prev_q, pulse_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/coe_load_arbiter.sv
// coe_load_arbiter: owns the single RAM write port. In RUN the CPU drives it
// combinationally; a start press hands it to the UART COE loader, which holds
// the CPU in reset, reads a 4-byte little-endian word count N, then writes N
// little-endian words at addresses 0..N-1, and finally releases the CPU.
//   iFpgaClk/iFpgaRst           : clock, asynchronous active-high reset
//   iStartReceiveCoe            : raw start button
//   iRxValid/iRxData            : UART byte strobe and data
//   iCpuMemWe/Addr/Wdata        : CPU write request
//   oMemWe/oMemAddr/oMemWdata   : RAM write port
//   oCpuRst, oLoading           : CPU reset request, loader owns port
//   oDone, oError               : sticky load outcome
// Optional build macro COE_CHECKSUM_EN: a trailer byte equal to the XOR of all
// data bytes must follow word N; a mismatch ends the load in ERR.
module coe_load_arbiter
    import coe_load_pkg::*;
#(
    parameter int ADDR_W          = 14,
    parameter int MAX_WORDS       = 16384,
    parameter int TIMEOUT_CYCLES  = 2_000_000,
    parameter int POST_RST_CYCLES = 4
) (
    input  logic              iFpgaClk,
    input  logic              iFpgaRst,
    input  logic              iStartReceiveCoe,
    input  logic              iRxValid,
    input  logic [7:0]        iRxData,
    input  logic              iCpuMemWe,
    input  logic [ADDR_W-1:0] iCpuMemAddr,
    input  logic [31:0]       iCpuMemWdata,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [31:0]       oMemWdata,
    output logic              oCpuRst,
    output logic              oLoading,
    output logic              oDone,
    output logic              oError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(POST_RST_CYCLES + 1);
    localparam logic [LANE_W-1:0] HDR_LAST  = LANE_W'(HDR_BYTES - 1);
    localparam logic [LANE_W-1:0] WORD_LAST = LANE_W'(BYTES_PER_WORD - 1);

    logic start;

    btn_edge_sync u_start (
        .clk_i   (iFpgaClk),
        .rst_i   (iFpgaRst),
        .btn_i   (iStartReceiveCoe),
        .pulse_o (start)
    );

    coe_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   nwords_q, nwords_d;
    logic [LANE_W-1:0] bcnt_q, bcnt_d;
    logic [TW-1:0]     tout_q, tout_d;
    logic [PW-1:0]     post_q, post_d;
    logic              done_q, done_d, err_q, err_d, we_q, we_d;
    logic [31:0]       shift_q, shift_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       word_w;
    logic              timeout_w, last_word_w;
`ifdef COE_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              trl_q, trl_d;
`endif

    assign word_w      = put_lane(shift_q, bcnt_q, iRxData);
    assign timeout_w   = (tout_q == TW'(TIMEOUT_CYCLES - 1));
    assign last_word_w = (({1'b0, addr_q} + (ADDR_W+1)'(1)) == nwords_q);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        nwords_d = nwords_q;
        bcnt_d   = bcnt_q;
        tout_d   = tout_q;
        post_d   = post_q;
        done_d   = done_q;
        err_d    = err_q;
        we_d     = 1'b0;
        shift_d  = shift_q;
        wdata_d  = wdata_q;
        waddr_d  = waddr_q;
`ifdef COE_CHECKSUM_EN
        csum_d   = csum_q;
        trl_d    = trl_q;
`endif
        // A press restarts the load from any state except RELEASE.
        if (start && state_q != ST_RELEASE) begin
            state_d = ST_HDR;
            addr_d  = '0;
            bcnt_d  = '0;
            tout_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
`ifdef COE_CHECKSUM_EN
            csum_d  = '0;
            trl_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (iRxValid) begin
                        tout_d  = '0;
                        shift_d = word_w;
                        if (bcnt_q == HDR_LAST) begin
                            bcnt_d = '0;
                            if (word_w == 32'd0 || word_w > 32'(MAX_WORDS)) begin
                                state_d = ST_ERR;
                                err_d   = 1'b1;
                            end else begin
                                nwords_d = word_w[ADDR_W:0];
                                state_d  = ST_DATA;
                            end
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else if (timeout_w) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        bcnt_d  = '0;
                    end else begin
                        tout_d = tout_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (iRxValid) begin
                        tout_d = '0;
`ifdef COE_CHECKSUM_EN
                        if (trl_q) begin
                            if (iRxData == csum_q) begin
                                state_d = ST_RELEASE;
                                post_d  = '0;
                            end else begin
                                state_d = ST_ERR;
                                err_d   = 1'b1;
                            end
                        end else begin
                            csum_d = csum_q ^ iRxData;
`endif
                            shift_d = word_w;
                            if (bcnt_q == WORD_LAST) begin
                                bcnt_d  = '0;
                                we_d    = 1'b1;
                                wdata_d = word_w;
                                waddr_d = addr_q;
                                addr_d  = addr_q + 1'b1;
                                if (last_word_w) begin
`ifdef COE_CHECKSUM_EN
                                    trl_d   = 1'b1;
`else
                                    state_d = ST_RELEASE;
                                    post_d  = '0;
`endif
                                end
                            end else begin
                                bcnt_d = bcnt_q + 1'b1;
                            end
`ifdef COE_CHECKSUM_EN
                        end
`endif
                    end else if (timeout_w) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        bcnt_d  = '0;
                    end else begin
                        tout_d = tout_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (post_q == PW'(POST_RST_CYCLES - 1)) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        post_d = post_q + 1'b1;
                    end
                end
                ST_RUN, ST_ERR: ;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge iFpgaClk or posedge iFpgaRst) begin
        if (iFpgaRst) begin
            state_q  <= ST_RUN;
            addr_q   <= '0;
            nwords_q <= '0;
            bcnt_q   <= '0;
            tout_q   <= '0;
            post_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
`ifdef COE_CHECKSUM_EN
            csum_q   <= '0;
            trl_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            nwords_q <= nwords_d;
            bcnt_q   <= bcnt_d;
            tout_q   <= tout_d;
            post_q   <= post_d;
            done_q   <= done_d;
            err_q    <= err_d;
            we_q     <= we_d;
`ifdef COE_CHECKSUM_EN
            csum_q   <= csum_d;
            trl_q    <= trl_d;
`endif
        end
    end

    // Datapath registers are only meaningful while qualified by we_q.
    always_ff @(posedge iFpgaClk) begin
        shift_q <= shift_d;
        wdata_q <= wdata_d;
        waddr_q <= waddr_d;
    end

    // CPU path is combinational in RUN; loader path is fully registered.
    assign oMemWe    = (state_q == ST_RUN) ? iCpuMemWe    : we_q;
    assign oMemAddr  = (state_q == ST_RUN) ? iCpuMemAddr  : waddr_q;
    assign oMemWdata = (state_q == ST_RUN) ? iCpuMemWdata : wdata_q;
    assign oCpuRst   = (state_q != ST_RUN);
    assign oLoading  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_RELEASE);
    assign oDone     = done_q;
    assign oError    = err_q;

endmodule

// File: tb/tb_coe_load_arbiter.sv
// Scoreboard bench for coe_load_arbiter: expected RAM writes are queued as the
// bytes are sent and popped by a monitor whenever the loader writes.
// Honours COE_CHECKSUM_EN (adds trailer bytes and checksum cases).
module tb_coe_load_arbiter;

    localparam int ADDR_W  = 14;
    localparam int MAXW    = 16384;
    localparam int TOUT    = 100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              btn = 1'b0;
    logic              rx_v = 1'b0;
    logic [7:0]        rx_d = 8'h00;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic              oMemWe, oCpuRst, oLoading, oDone, oError;
    logic [ADDR_W-1:0] oMemAddr;
    logic [31:0]       oMemWdata;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    int          cyc = 0;
    int          wr_cyc = 0;
    int          rel_cyc = 0;
    int          wr_base;
    logic [7:0]  tb_cs = 8'h00;
    logic [45:0] exp_q[$];

    coe_load_arbiter #(
        .ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TOUT), .POST_RST_CYCLES(4)
    ) dut (
        .iFpgaClk(clk), .iFpgaRst(rst), .iStartReceiveCoe(btn),
        .iRxValid(rx_v), .iRxData(rx_d),
        .iCpuMemWe(cpu_we), .iCpuMemAddr(cpu_addr), .iCpuMemWdata(cpu_wdata),
        .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWdata(oMemWdata),
        .oCpuRst(oCpuRst), .oLoading(oLoading), .oDone(oDone), .oError(oError)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Loader writes (CPU held in reset) are scored against the queue.
    always @(negedge clk) begin
        if (oMemWe === 1'b1 && oCpuRst === 1'b1) begin
            logic [45:0] e;
            n_wr++;
            wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", 64'(oMemAddr), 64'(e[45:32]));
                check_eq("wr_data", 64'(oMemWdata), 64'(e[31:0]));
            end
        end
    end

    task automatic press();
        btn = 1'b1;
        tb_cs = 8'h00;
        repeat (6) @(posedge clk);
        #1;
        check_eq("press_loading", 64'(oLoading), 64'd1);
        btn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_v = 1'b1;
        rx_d = b;
        @(posedge clk); #1;
        rx_v = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) begin
            tb_cs = tb_cs ^ w[8*i +: 8];
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic finish_load();
`ifdef COE_CHECKSUM_EN
        send_byte(tb_cs);
`endif
    endtask

    task automatic wait_release(input string tag);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (oCpuRst === 1'b0) break;
        end
        rel_cyc = cyc;
        check_eq(tag, 64'(oCpuRst), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cpurst", 64'(oCpuRst), 64'd0);
        check_eq("rst_loading", 64'(oLoading), 64'd0);
        check_eq("rst_done", 64'(oDone), 64'd0);
        check_eq("rst_error", 64'(oError), 64'd0);
        check_eq("rst_we", 64'(oMemWe), 64'd0);
        rst = 1'b0;

        // CPU passthrough in RUN
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 14'd5; cpu_wdata = 32'hDEADBEEF;
        #1;
        check_eq("run_we", 64'(oMemWe), 64'd1);
        check_eq("run_addr", 64'(oMemAddr), 64'd5);
        check_eq("run_wdata", 64'(oMemWdata), 64'hDEADBEEF);
        cpu_we = 1'b0;

        // Normal 3-word load, CPU write blocked during HDR
        press();
        cpu_we = 1'b1;
        #1;
        check_eq("hdr_cpu_blocked", 64'(oMemWe), 64'd0);
        check_eq("hdr_cpurst", 64'(oCpuRst), 64'd1);
        cpu_we = 1'b0;
        wr_base = n_wr;
        send_hdr(32'd3);
        load_word(14'd0, 32'h44332211);
        load_word(14'd1, 32'h88776655);
        load_word(14'd2, 32'hCCBBAA99);
        finish_load();
        wait_release("norm_release");
`ifndef COE_CHECKSUM_EN
        check_eq("norm_rel_gap", 64'(rel_cyc - wr_cyc), 64'd4);
`endif
        check_eq("norm_done", 64'(oDone), 64'd1);
        check_eq("norm_loading", 64'(oLoading), 64'd0);
        check_eq("norm_error", 64'(oError), 64'd0);
        check_eq("norm_nwr", 64'(n_wr - wr_base), 64'd3);

        // Zero header -> ERR, then recover
        press();
        wr_base = n_wr;
        send_hdr(32'd0);
        repeat (3) @(posedge clk); #1;
        check_eq("bad_error", 64'(oError), 64'd1);
        check_eq("bad_cpurst", 64'(oCpuRst), 64'd1);
        check_eq("bad_loading", 64'(oLoading), 64'd0);
        check_eq("bad_nwr", 64'(n_wr - wr_base), 64'd0);
        press();
        check_eq("recov_err_clr", 64'(oError), 64'd0);
        send_hdr(32'd1);
        load_word(14'd0, 32'hCAFEF00D);
        finish_load();
        wait_release("recov_release");
        check_eq("recov_done", 64'(oDone), 64'd1);
        check_eq("recov_error", 64'(oError), 64'd0);

        // Oversized header -> ERR
        press();
        send_hdr(32'(MAXW + 1));
        repeat (3) @(posedge clk); #1;
        check_eq("big_error", 64'(oError), 64'd1);
        check_eq("big_done", 64'(oDone), 64'd0);

        // Timeout after one word plus two bytes
        press();
        wr_base = n_wr;
        send_hdr(32'd2);
        load_word(14'd0, 32'h0BADF00D);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (80) @(posedge clk); #1;
        check_eq("tout_early", 64'(oError), 64'd0);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (oError === 1'b1) break;
        end
        check_eq("tout_error", 64'(oError), 64'd1);
        check_eq("tout_cpurst", 64'(oCpuRst), 64'd1);
        check_eq("tout_nwr", 64'(n_wr - wr_base), 64'd1);

        // Restart mid-DATA after five bytes
        press();
        send_hdr(32'd2);
        load_word(14'd0, 32'h01020304);
        send_byte(8'h55);
        press();
        send_hdr(32'd1);
        load_word(14'd0, 32'hA5A55A5A);
        finish_load();
        wait_release("rst_mid_release");
        check_eq("restart_done", 64'(oDone), 64'd1);

        // Asynchronous reset mid-DATA
        press();
        send_hdr(32'd1);
        send_byte(8'h77);
        send_byte(8'h66);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_eq("arst_cpurst", 64'(oCpuRst), 64'd0);
        check_eq("arst_loading", 64'(oLoading), 64'd0);
        check_eq("arst_done", 64'(oDone), 64'd0);
        check_eq("arst_we", 64'(oMemWe), 64'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef COE_CHECKSUM_EN
        press();
        send_hdr(32'd1);
        load_word(14'd0, 32'h08040201);
        send_byte(8'h0F);
        wait_release("cs_ok_release");
        check_eq("cs_ok_done", 64'(oDone), 64'd1);
        press();
        wr_base = n_wr;
        send_hdr(32'd1);
        load_word(14'd0, 32'h08040201);
        send_byte(8'h0E);
        repeat (3) @(posedge clk); #1;
        check_eq("cs_bad_error", 64'(oError), 64'd1);
        check_eq("cs_bad_nwr", 64'(n_wr - wr_base), 64'd1);
`endif

        repeat (4) @(posedge clk); #1;
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
